// File: rtl/ysyx_22041207_mdu_if.sv
// Request/response bundle between the EX stage and ysyx_22041207_mdu.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// && !flush; a result transfers on a rising edge where out_valid && out_ready.
// The producer holds op/word/src1/src2 stable only up to the accepting edge.
// The unit holds result stable for as long as out_valid is high. flush cancels
// whatever is in flight at the next edge, and no transfer happens on that edge.
interface ysyx_22041207_mdu_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  logic [1:0]      dbg_state;

  modport master (
    output flush, in_valid, op, word, src1, src2, out_ready,
    input  in_ready, out_valid, result, busy, dbg_state
  );

  modport slave (
    input  flush, in_valid, op, word, src1, src2, out_ready,
    output in_ready, out_valid, result, busy, dbg_state
  );
endinterface

// File: rtl/ysyx_22041207_mdu.sv
// Iterative RV64M multiply/divide unit (one bit per cycle).
// Multiply: shift-add over a 2*XLEN accumulator. Divide: restoring shift-subtract.
// Operands are stored as magnitudes. Sign correction and result selection
// happen on a single fix-up edge.
// Optional build macro YSYX_22041207_MDU_ZERO_SKIP_EN: a multiply with a zero
// effective operand completes on the accepting edge. Results are unchanged.
module ysyx_22041207_mdu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input logic                clk,
  input logic                rst,
  ysyx_22041207_mdu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  state_t state, state_nxt;

  // accept-time decode
  logic              w_in, sgn1_in, sgn2_in, neg1, neg2;
  logic [XLEN-1:0]   a_eff, b_eff, abs1, abs2, min_eff, mq_base, short_res;
  logic              div_zero, div_ovf, mul_zero, shortcut, accept;
  logic [5:0]        sh_amt;
  logic [CNT_W-1:0]  n_in;

  // iteration state
  logic [2:0]        op_q;
  logic              w_q, neg_p_q, neg_r_q;
  logic [CNT_W-1:0]  n_q, cnt;
  logic [XLEN-1:0]   mq, dvs, rem, result_q;
  logic [2*XLEN-1:0] prod;

  // per-cycle datapath values
  logic [2*XLEN-1:0] mul_step, prod_s;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_step, mq_step, q_s, r_s, low_res, final_res;

  assign accept = (state == S_IDLE) && bus.in_valid && !bus.flush;

  // Operand decode: effective width, signedness, magnitudes, shortcut cases
  always_comb begin
    w_in     = (XLEN == 64) && bus.word && ((bus.op == 3'd0) || bus.op[2]);
    sgn1_in  = (bus.op != 3'd3) && !(bus.op[2] && bus.op[0]);
    sgn2_in  = (bus.op == 3'd0) || (bus.op == 3'd1) || (bus.op[2] && !bus.op[0]);
    a_eff    = w_in ? sext32(bus.src1[31:0]) : bus.src1;
    b_eff    = w_in ? sext32(bus.src2[31:0]) : bus.src2;
    neg1     = sgn1_in && a_eff[XLEN-1];
    neg2     = sgn2_in && b_eff[XLEN-1];
    abs1     = neg1 ? -a_eff : a_eff;
    abs2     = neg2 ? -b_eff : b_eff;
    // W magnitudes live in the low 32 bits (the most negative value included)
    if (w_in) begin
      abs1 = XLEN'(abs1[31:0]);
      abs2 = XLEN'(abs2[31:0]);
    end
    min_eff  = w_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = bus.op[2] && (b_eff == '0);
    div_ovf  = bus.op[2] && !bus.op[0] && (a_eff == min_eff) && (b_eff == '1);
`ifdef YSYX_22041207_MDU_ZERO_SKIP_EN
    mul_zero = !bus.op[2] && ((a_eff == '0) || (b_eff == '0));
`else
    mul_zero = 1'b0;
`endif
    shortcut  = div_zero || div_ovf || mul_zero;
    short_res = '0;
    if (div_zero)     short_res = bus.op[1] ? a_eff : '1;
    else if (div_ovf) short_res = bus.op[1] ? '0 : a_eff;
    n_in    = w_in ? CNT_W'(32) : CNT_W'(XLEN);
    // Left-align the scanned operand so its MSB is always at XLEN-1
    sh_amt  = w_in ? 6'd32 : 6'd0;
    mq_base = (bus.op[2] ? abs1 : abs2) << sh_amt;
  end

  // One multiply/divide step, plus the sign fix-up and result select
  always_comb begin
    mul_step  = {prod[2*XLEN-2:0], 1'b0} +
                (mq[XLEN-1] ? {{XLEN{1'b0}}, dvs} : {(2*XLEN){1'b0}});
    rem_sh    = {rem, mq[XLEN-1]};
    rem_ge    = rem_sh >= {1'b0, dvs};
    rem_step  = rem_ge ? XLEN'(rem_sh - {1'b0, dvs}) : rem_sh[XLEN-1:0];
    mq_step   = {mq[XLEN-2:0], op_q[2] && rem_ge};
    prod_s    = neg_p_q ? -prod : prod;
    q_s       = neg_p_q ? -mq : mq;
    r_s       = neg_r_q ? -rem : rem;
    low_res   = !op_q[2] ? prod_s[XLEN-1:0] : (op_q[1] ? r_s : q_s);
    final_res = (!op_q[2] && (op_q != 3'd0)) ? prod_s[2*XLEN-1:XLEN]
              : (w_q ? sext32(low_res[31:0]) : low_res);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = shortcut ? S_DONE : S_CALC;
      S_CALC: if (bus.flush) state_nxt = S_IDLE;
              else if (cnt == n_q) state_nxt = S_DONE;
      S_DONE: if (bus.flush || bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from state
  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    bus.busy      = (state == S_CALC) || (state == S_DONE);
    bus.result    = result_q;
    bus.dbg_state = state;
  end

  // Datapath: latch on accept, iterate in CALC, write the result on fix-up
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      w_q      <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      n_q      <= '0;
      cnt      <= '0;
      prod     <= '0;
      rem      <= '0;
      mq       <= '0;
      dvs      <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= bus.op;
      w_q     <= w_in;
      neg_p_q <= neg1 ^ neg2;
      neg_r_q <= neg1;
      n_q     <= n_in;
      cnt     <= '0;
      prod    <= '0;
      rem     <= '0;
      mq      <= mq_base;
      dvs     <= bus.op[2] ? abs2 : abs1;
      if (shortcut) result_q <= short_res;
    end else if ((state == S_CALC) && !bus.flush) begin
      if (cnt != n_q) begin
        prod <= mul_step;
        rem  <= rem_step;
        mq   <= mq_step;
        cnt  <= cnt + CNT_W'(1);
      end else begin
        result_q <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_mdu.sv
// Bench for ysyx_22041207_mdu (XLEN=64): directed cases, flush/reset aborts,
// and randomized operations checked against an arithmetic reference model.
// Latency is counted with the accepting edge as edge 1.
module tb_ysyx_22041207_mdu;

  logic clk;
  logic rst;
  ysyx_22041207_mdu_if #(.XLEN(64)) bus ();

  ysyx_22041207_mdu #(.XLEN(64), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_w(input logic [2:0] op, input logic word);
    return word && ((op == 3'd0) || op[2]);
  endfunction

  function automatic logic [63:0] model_res(input logic [2:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
    logic w, sg;
    logic [127:0] ea, eb, p;
    logic [63:0] x, y, q, r, res;
    w = is_w(op, word);
    if (!op[2]) begin
      ea = (op != 3'd3) ? {{64{a[63]}}, a} : {64'd0, a};
      eb = (op <= 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
      p  = ea * eb;
      if (op == 3'd0) return w ? sx32(p[31:0]) : p[63:0];
      return p[127:64];
    end
    sg = !op[0];
    x = w ? (sg ? sx32(a[31:0]) : {32'd0, a[31:0]}) : a;
    y = w ? (sg ? sx32(b[31:0]) : {32'd0, b[31:0]}) : b;
    if (y == 64'd0) begin
      q = '1;
      r = x;
    end else if (sg && (y == '1) && (x == (w ? sx32(32'h8000_0000) : 64'h8000_0000_0000_0000))) begin
      q = x;
      r = 64'd0;
    end else if (sg) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    res = op[1] ? r : q;
    return w ? sx32(res[31:0]) : res;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic word,
                                   input logic [63:0] a, input logic [63:0] b);
    logic w;
    logic [63:0] x, y;
    w = is_w(op, word);
    x = w ? sx32(a[31:0]) : a;
    y = w ? sx32(b[31:0]) : b;
    if (op[2] && (y == 64'd0)) return 1;
    if (op[2] && !op[0] && (y == '1) &&
        (x == (w ? sx32(32'h8000_0000) : 64'h8000_0000_0000_0000))) return 1;
`ifdef YSYX_22041207_MDU_ZERO_SKIP_EN
    if (!op[2] && ((x == 64'd0) || (y == 64'd0))) return 1;
`endif
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'h0000_0000_8000_0000;
      4: v = {32'd0, 16'd0, 16'($urandom)};
      5: v = sx32($urandom);
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // ---------------- drivers ----------------
  // Called just after a negedge while the unit is idle; returns 1ns after the accepting edge.
  task automatic accept_op(input logic [2:0] op, input logic word,
                           input logic [63:0] a, input logic [63:0] b);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.word     = word;
    bus.src1     = a;
    bus.src2     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom_range(0, 7));
    bus.word     = 1'($urandom_range(0, 1));
    bus.src1     = {$urandom, $urandom};
    bus.src2     = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input int hold);
    int lat;
    int exp_lat;
    logic [63:0] got;
    exp_q.push_back(model_res(op, word, a, b));
    exp_lat = model_lat(op, word, a, b);
    accept_op(op, word, a, b);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    got = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", bus.result, got);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    check("result", got, exp_q.pop_front());
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  // Cancels a long multiply with flush (or rst) on its 20th edge.
  task automatic abort_test(input logic use_rst);
    int seen;
    accept_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (19) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else bus.flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.flush = 1'b0;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    if (use_rst) check("abort_rst_result", bus.result, 64'd0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.word      = 1'b0;
    bus.src1      = 64'd0;
    bus.src2      = 64'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", bus.result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 10);
    check("mul_7_m3_const", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd3, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    check("mulhu_const", bus.result, 64'd6);
    run_op(3'd4, 1'b0, -64'sd20, 64'd6, 0);
    check("div_const", bus.result, -64'sd3);
    run_op(3'd6, 1'b0, -64'sd20, 64'd6, 0);
    check("rem_const", bus.result, -64'sd2);
    run_op(3'd4, 1'b1, 64'h0000_0001_8000_0000, '1, 1);
    check("divw_ovf_const", bus.result, 64'hFFFF_FFFF_8000_0000);
    run_op(3'd5, 1'b0, 64'h1234, 64'd0, 0);
    check("divu_zero_const", bus.result, '1);
    run_op(3'd7, 1'b0, 64'h1234, 64'd0, 0);
    check("remu_zero_const", bus.result, 64'h1234);
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
    run_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
    run_op(3'd2, 1'b0, '1, '1, 0);
    run_op(3'd0, 1'b1, 64'h1234_5678_8000_0001, 64'hFFFF_0000_7FFF_FFFF, 0);
    run_op(3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0003, 0);
    run_op(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0);
    run_op(3'd0, 1'b0, 64'd0, 64'h1234_5678_9ABC_DEF0, 0);

    // flush with in_valid while idle: the request is dropped
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.op       = 3'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("idle_flush_busy", 64'(bus.busy), 64'd0);
    check("idle_flush_in_ready", 64'(bus.in_ready), 64'd1);

    // flush together with out_ready in DONE: result discarded, back to idle
    accept_op(3'd5, 1'b0, 64'h55, 64'd0);
    @(negedge clk);
    check("done_flush_pre_valid", 64'(bus.out_valid), 64'd1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("done_flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("done_flush_in_ready", 64'(bus.in_ready), 64'd1);

    // aborts mid-multiply
    abort_test(1'b0);
    abort_test(1'b1);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(),
             $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_mdu.md
Name: ysyx_22041207_mdu

Overview:
- Parametrised iterative multiply/divide unit; successor to the single-op stalling multiply path inside the execute-stage ALU.
- Covers the full RV64M set: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, plus the W variants.
- Uses a valid/ready handshake on input and output, replacing the ALU-side wait flag.
- Sits beside the ALU in EX. The pipeline holds the instruction until out_valid and uses flush to cancel on redirect.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- flush, input, 1, synchronous cancel of any in-flight operation.
- in_valid, input, 1, operation request.
- in_ready, output, 1, unit can accept a request (high only in IDLE).
- op, input, 3, operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- word, input, 1, W-variant: operate on bits [31:0], sign-extend the 32-bit result; ignored for op 1-3 and when XLEN=32.
- src1, input, XLEN, rs1 operand (dividend / multiplicand).
- src2, input, XLEN, rs2 operand (divisor / multiplier).
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts result.
- result, output, XLEN, final result; stable while out_valid=1.
- busy, output, 1, high in CALC or DONE.

Behaviour:
- Reset: clk/rst as above. rst=1 at an edge forces IDLE. Reset values: in_ready=1, out_valid=0, busy=0, result=0, counter=0.
- rst overrides flush and all handshakes, including mid-operation.
- States: IDLE -> CALC -> DONE -> IDLE.
- IDLE: in_ready=1. An edge with in_valid&in_ready&~flush latches op, word and absolute-value operands, then goes to CALC with N = word ? 32 : XLEN.
- Special-case shortcut: instead of CALC, go straight to DONE with the result already set:
  - divisor zero: quotient = all ones; remainder = dividend.
  - signed overflow (dividend = most-negative value, divisor = -1, at the effective width): quotient = dividend; remainder = 0.
- CALC, multiply: radix-2 shift-add over a 2N-bit accumulator, one bit per cycle.
- CALC, divide: restoring shift-subtract, one bit per cycle.
- Sign handling for multiply:
  - MUL/MULH: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU: both unsigned.
  - Negate the product at the end when the operand signs differ.
- Sign handling for divide:
  - Quotient takes sign = sign1 XOR sign2.
  - Remainder takes the sign of the dividend.
- Result selection: MUL returns low N bits; MULH* return high XLEN bits.
- W variants: result = sign-extend of bit 31 of the 32-bit result (for both W quotient and W remainder).
- Leaving CALC: after N iterations, one fix-up edge (sign correction + select) moves to DONE.
- Latency: out_valid goes high exactly N+2 edges after the accepting edge (66 for 64-bit ops, 34 for W ops); special cases take 1 edge.
- DONE: out_valid=1 and result held until an edge with out_ready=1. That edge returns to IDLE, so in_ready=1 the following cycle.
  - No back-to-back accept in the same cycle as the out handshake.
- Flush: any state goes to IDLE at the next edge, out_valid=0, and the result is discarded.
  - flush with in_valid in IDLE: the request is not accepted.
  - flush in DONE with out_ready=1: the result is discarded; the consumer must ignore it.
- Input changes while busy are ignored; operands are latched at accept.
- No X on result at any time after reset.

Optional Feature:
- Macro: YSYX_22041207_MDU_ZERO_SKIP_EN.
- Defined: a multiply with either effective operand zero (low 32 bits for MUL W) skips CALC. It goes to DONE in 1 edge with result 0.
- Undefined: zero-operand multiplies take the full N+2 latency. Results are identical in both builds; only timing differs.

Test Plan:
- MUL src1=7, src2=-3 (0xFFFF_FFFF_FFFF_FFFD), word=0 -> out_valid 66 edges after accept, result=0xFFFF_FFFF_FFFF_FFEB; MULHU with the same operands -> result=6.
- DIV src1=-20, src2=6 -> result=-3; REM with the same operands -> result=-2.
- DIVW src1=0x0000_0001_8000_0000, src2=-1, word=1 -> overflow shortcut in 1 edge, result=0xFFFF_FFFF_8000_0000.
- DIVU src2=0, src1=0x1234 -> result=0xFFFF_FFFF_FFFF_FFFF; REMU with the same operands -> result=0x1234; both in 1 edge.
- Hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0. Then pulse out_ready -> next cycle in_ready=1, out_valid=0.
- Flush at edge 20 of a 66-edge MUL -> next cycle IDLE, out_valid never rises. A new request right after produces the correct result. Repeat the same check with rst instead of flush.
